// File: rtl/tone_pkg.sv
// tone_pkg: shared clock default, channel state encoding and popcount helper
package tone_pkg;
  localparam int CLK_PERIOD_DEF = 10;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic int unsigned popcount(input logic [15:0] v);
    int unsigned n;
    n = 0;
    for (int k = 0; k < 16; k++) n += 32'(v[k]);
    return n;
  endfunction
endpackage

// File: rtl/tone_channel.sv
// tone_channel: one double-buffered PWM tone channel with ns period counter
module tone_channel
  import tone_pkg::*;
#(
  parameter int PERIOD_W   = 32,
  parameter int DUTY_W     = 8,
  parameter int CLK_PERIOD = CLK_PERIOD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DUTY_W-1:0]   duty,
  output logic                wave,
  output logic                sync
);
  state_t state;
  logic [PERIOD_W-1:0] shadow_period, shadow_thr, act_period, act_thr, counter;
  logic [DUTY_W-1:0] shadow_duty;
  logic pending, load_q;
  logic [PERIOD_W:0] sum;
  logic [PERIOD_W+DUTY_W-1:0] product;
  logic [PERIOD_W-1:0] thr_calc, nxt_period, nxt_thr, nxt_counter;
  logic start, wrap, bound, commit, run;
  always_comb begin
    sum = {1'b0, counter} + (PERIOD_W+1)'(CLK_PERIOD);
    product = (PERIOD_W+DUTY_W)'(shadow_period) * (PERIOD_W+DUTY_W)'(shadow_duty);
    thr_calc = PERIOD_W'(product >> DUTY_W);
    start = state == ST_IDLE && en && (act_period != '0 || pending);
    // a zero active period wraps every cycle, so pending is re-checked each cycle
    wrap = state == ST_RUN && en && sum >= {1'b0, act_period};
    bound = start || wrap;
    commit = bound && pending;
    run = en && (state == ST_RUN || start);
    nxt_period = commit ? shadow_period : act_period;
    nxt_thr = commit ? shadow_thr : act_thr;
    nxt_counter = (run && !bound) ? sum[PERIOD_W-1:0] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shadow_period <= '0;
      shadow_duty <= '0;
      shadow_thr <= '0;
      act_period <= '0;
      act_thr <= '0;
      counter <= '0;
      pending <= 1'b0;
      load_q <= 1'b0;
      wave <= 1'b0;
      sync <= 1'b0;
    end else begin
      if (load) begin
        shadow_period <= period;
        shadow_duty <= duty;
      end
      load_q <= load;
      if (load_q) shadow_thr <= thr_calc;
      pending <= load_q || (pending && !commit);
      act_period <= nxt_period;
      act_thr <= nxt_thr;
      counter <= nxt_counter;
      state <= run ? ST_RUN : ST_IDLE;
      sync <= bound && nxt_period != '0;
      wave <= run && nxt_counter < nxt_thr;
    end
  end
endmodule

// File: rtl/poly_tone_generator.sv
// poly_tone_generator: multi-channel PWM tone generator with registered voice count
module poly_tone_generator
  import tone_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int PERIOD_W   = 32,
  parameter int DUTY_W     = 8,
  parameter int CLK_PERIOD = CLK_PERIOD_DEF,
  parameter int MIX_W      = $clog2(CHANNELS+1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS-1:0]          load,
  input  logic [CHANNELS*PERIOD_W-1:0] period,
  input  logic [CHANNELS*DUTY_W-1:0]   duty,
  output logic [CHANNELS-1:0]          wave,
  output logic [CHANNELS-1:0]          sync,
  output logic [MIX_W-1:0]             mix
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    tone_channel #(
      .PERIOD_W(PERIOD_W),
      .DUTY_W(DUTY_W),
      .CLK_PERIOD(CLK_PERIOD)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(en[g]),
      .load(load[g]),
      .period(period[g*PERIOD_W +: PERIOD_W]),
      .duty(duty[g*DUTY_W +: DUTY_W]),
      .wave(wave[g]),
      .sync(sync[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mix <= '0;
    else mix <= MIX_W'(popcount(16'(wave)));
  end
endmodule

// File: tb/tb_poly_tone_generator.sv
// tb_poly_tone_generator: vector table, corner sequences and random run against a cycle-index model
module tb_poly_tone_generator;
  localparam int CH = 4, PW = 32, DW = 8, CP = 10;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [CH-1:0] en = '0, load = '0;
  logic [CH*PW-1:0] period = '0;
  logic [CH*DW-1:0] duty = '0;
  logic [CH-1:0] wave, sync;
  logic [2:0] mix;
  int tests = 0, fails = 0;

  poly_tone_generator #(.CHANNELS(CH), .PERIOD_W(PW), .DUTY_W(DW), .CLK_PERIOD(CP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .period(period), .duty(duty),
    .wave(wave), .sync(sync), .mix(mix)
  );

  always #5 clk = ~clk;

  typedef struct {int p; int d; int cyc; int hi;} vec_t;

  // model tracks position within the period in whole cycles
  bit m_run[CH], m_pend[CH], m_lq[CH];
  longint unsigned m_ap[CH], m_at[CH], m_sp[CH], m_sd[CH], m_st[CH], m_pos[CH];
  logic [CH-1:0] m_wave, m_sync;
  int m_mix;

  function automatic longint unsigned cdiv(longint unsigned x);
    return (x + CP - 1) / CP;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0; m_pend[i] = 0; m_lq[i] = 0;
      m_ap[i] = 0; m_at[i] = 0; m_sp[i] = 0; m_sd[i] = 0; m_st[i] = 0; m_pos[i] = 0;
    end
    m_wave = '0; m_sync = '0; m_mix = 0;
  endtask

  task automatic model_step();
    int nm;
    nm = 0;
    for (int i = 0; i < CH; i++) nm += int'(m_wave[i]);
    for (int i = 0; i < CH; i++) begin
      bit bnd, cm;
      bnd = 0;
      if (!m_run[i]) begin
        if (en[i] && (m_ap[i] != 0 || m_pend[i])) begin m_run[i] = 1; bnd = 1; end
      end else if (!en[i]) m_run[i] = 0;
      else if (m_pos[i] + 1 >= cdiv(m_ap[i])) bnd = 1;
      cm = bnd && m_pend[i];
      if (cm) begin m_ap[i] = m_sp[i]; m_at[i] = m_st[i]; end
      m_pos[i] = (bnd || !m_run[i]) ? 0 : m_pos[i] + 1;
      m_pend[i] = (m_pend[i] && !cm) || m_lq[i];
      if (m_lq[i]) m_st[i] = (m_sp[i] * m_sd[i]) >> DW;
      if (load[i]) begin
        m_sp[i] = longint'(period[i*PW +: PW]);
        m_sd[i] = longint'(duty[i*DW +: DW]);
      end
      m_lq[i] = load[i];
      m_sync[i] = bnd && m_ap[i] != 0;
      m_wave[i] = m_run[i] && m_pos[i] < cdiv(m_at[i]);
    end
    m_mix = nm;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle", 32'({wave, sync, mix}), 32'({m_wave, m_sync, 3'(m_mix)}));
  endtask

  task automatic do_reset();
    en = '0; load = '0;
    rst_n = 1'b0;
    model_reset();
    #1 check("reset", 32'({wave, sync, mix}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_ch(input int ch, input int p, input int d);
    period[ch*PW +: PW] = PW'(p);
    duty[ch*DW +: DW] = DW'(d);
    load[ch] = 1'b1;
    tick();
    load[ch] = 1'b0;
  endtask

  task automatic measure(input int ch, output int wait_n, output int gap, output int hi);
    wait_n = 0; gap = 0; hi = 0;
    while (!sync[ch] && wait_n < 60) begin tick(); wait_n++; end
    if (sync[ch]) begin
      do begin
        hi += int'(wave[ch]);
        tick();
        gap++;
      end while (!sync[ch] && gap < 60);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    int w, g, h;
    int unsigned seen;
    tbl = '{'{100, 128, 10, 5}, '{95, 128, 10, 5}, '{200, 64, 20, 5}, '{100, 0, 10, 0},
            '{100, 255, 10, 10}, '{37, 128, 4, 2}, '{0, 128, 0, 0}};
    #2;
    do_reset();
    repeat (50) tick();
    check("idle", 32'({wave, sync, mix}), 32'd0);

    for (int k = 0; k < 7; k++) begin
      do_reset();
      load_ch(0, tbl[k].p, tbl[k].d);
      en[0] = 1'b1;
      measure(0, w, g, h);
      check("tbl_period", g, tbl[k].cyc);
      check("tbl_high", h, tbl[k].hi);
    end

    do_reset();
    load_ch(0, 100, 128);
    tick();
    tick();
    en[0] = 1'b1;
    measure(0, w, g, h);
    check("en_latency", w, 1);
    check("first_period", g, 10);
    repeat (3) tick();
    load_ch(0, 200, 64);
    measure(0, w, g, h);
    check("glitch_wait", w, 6);
    check("glitch_period", g, 20);
    check("glitch_high", h, 5);

    repeat (19) tick();
    load_ch(0, 300, 128);
    measure(0, w, g, h);
    check("wrap_load_wait", w, 0);
    check("wrap_load_old", g, 20);
    measure(0, w, g, h);
    check("wrap_load_new", g, 30);
    check("wrap_load_high", h, 15);

    repeat (2) tick();
    load_ch(0, 120, 128);
    load_ch(0, 60, 128);
    measure(0, w, g, h);
    check("dbl_load_period", g, 6);
    check("dbl_load_high", h, 3);

    do_reset();
    for (int i = 0; i < CH; i++) load_ch(i, (i + 1) * 100, 128);
    tick();
    en = '1;
    seen = 0;
    repeat (150) begin
      tick();
      seen |= 32'd1 << mix;
    end
    check("mix_values", seen, 32'h1f);
    for (int n = 0; n < 20 && mix == 0; n++) tick();
    #2 rst_n = 1'b0;
    #1 check("async_rst", 32'({wave, sync, mix}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();
    load_ch(0, 100, 128);
    measure(0, w, g, h);
    check("restart_period", g, 10);
    check("restart_high", h, 5);

    do_reset();
    repeat (1500) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 49) == 0) en[i] = ~en[i];
        load[i] = ($urandom_range(0, 19) == 0);
        if (load[i]) begin
          period[i*PW +: PW] = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom_range(1, 400));
          duty[i*DW +: DW] = DW'($urandom_range(0, 255));
        end
      end
      tick();
    end
    en = '0;
    load = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/poly_tone_generator.md
# poly_tone_generator

Parametrised multi-channel successor to the single-tone square-wave generator. Each channel runs a period counter in nanosecond units and drives a PWM tone with programmable duty. Period and duty updates are double-buffered and applied glitch-free at period boundaries. A registered voice-count output feeds the audio mixer/DAC stage, and the per-channel waves feed the buzzer/PWM pins.

## Interface
- CHANNELS, 4: number of independent tone channels (1..16)
- PERIOD_W, 32: width of period and counter, in ns
- DUTY_W, 8: duty resolution; duty/2^DUTY_W is the high fraction
- CLK_PERIOD, 10: clock period in ns, added to counter each cycle
- MIX_W, $clog2(CHANNELS+1): width of mix output

- clk  input  1  system clock; all state on posedge clk
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- en  input  CHANNELS  per-channel enable, level
- load  input  CHANNELS  per-channel strobe; captures period/duty slice into shadow
- period  input  CHANNELS*PERIOD_W  channel i at [i*PERIOD_W +: PERIOD_W], ns
- duty  input  CHANNELS*DUTY_W  channel i at [i*DUTY_W +: DUTY_W]
- wave  output  CHANNELS  registered tone output per channel
- sync  output  CHANNELS  one-cycle pulse on the cycle a new period starts
- mix  output  MIX_W  registered count of channels whose wave is high

## Operation
- Per-channel registers: shadow_period and shadow_duty; shadow_thr; pending flag; act_period and act_thr; counter; state.
- load[i] captures the period and duty slices into shadow_period and shadow_duty at that edge.
- Next edge: shadow_thr <= (shadow_period * shadow_duty) >> DUTY_W, full PERIOD_W+DUTY_W product truncated to PERIOD_W. pending <= 1 on the same edge.
- States per channel are IDLE and RUN.
- IDLE (reset, or en=0): counter=0, wave=0, sync=0. Shadow and pending are still written.
- IDLE->RUN when en=1 and act_period!=0 (or pending=1). On the entry edge: if pending, commit shadow to act and clear pending. counter<=0, sync<=1.
- RUN: if en=0, go IDLE on the next edge; counter<=0, wave<=0. In-progress period is abandoned.
- RUN, act_period==0 after commit: channel silent (wave=0, sync=0), stays RUN. Re-checks pending every cycle.
- RUN wrap: when counter + CLK_PERIOD >= act_period, counter<=0, sync<=1, and pending shadow is committed (pending cleared). Otherwise counter <= counter + CLK_PERIOD.
- Addition is done at PERIOD_W+1 bits; no wrap-around overflow.
- wave <= (state==RUN) && (next counter < next act_thr). Compares against values after the edge, so a committed duty takes effect on the first cycle of the new period.
- duty=0 gives wave constantly 0. duty=2^DUTY_W-1 gives high except the final partial step.
- Period not a multiple of CLK_PERIOD: the period rounds up to ceil(period/CLK_PERIOD) cycles.
- mix <= popcount(wave) (current registered wave), so mix lags wave by one cycle.

## Timing
- Reset values: wave=0, sync=0, mix=0, counter=0, act_*=0, shadow_*=0, pending=0, state=IDLE.
- load at edge N: shadow at N, pending at N+1. Earliest commit is the wrap evaluated at edge N+2.
- load asserted on the same edge as a wrap is not applied at that wrap; it is applied at the next one.
- load while pending=1: the newer value overwrites the older; only the last value is committed.
- Enable latency: en rises before edge N, so sync=1 and the first wave value appear after edge N.
- Period in cycles = ceil(act_period / CLK_PERIOD); high cycles = ceil(act_thr / CLK_PERIOD).
- rst_n asserted mid-period: all outputs clear immediately (asynchronous). Release resumes in IDLE.
- Channels are fully independent; no arbitration between them.

## Structure
- Shared package tone_pkg: the default CLK_PERIOD, state encoding (ST_IDLE, ST_RUN), and a popcount function.
- One sub-module: tone_channel, holding a single channel's shadow/active registers, counter, FSM, wave and sync.
- Top instantiates CHANNELS copies in a generate loop, slices the buses, and registers mix.

## Test plan
- Reset/idle: rst_n=0 then release with en=0 -> wave=0, sync=0 and mix=0 for 50 cycles.
- Basic tone: CLK_PERIOD=10, ch0 load period=100, duty=128, en=1 -> 10-cycle period, wave high 5 then low 5, sync every 10th cycle; mix follows wave one cycle late.
- Glitch-free update: mid-period, load period=200, duty=64 -> current 10-cycle period completes unchanged; next period is 20 cycles with 5 high.
- Edges: duty=0 -> wave always 0, sync still pulses. period=0 -> no sync, wave 0. period=95 -> 10-cycle period.
- Load on wrap edge and double load: load on the sync cycle applies one period later. Two loads before a wrap -> only the second value appears.
- Multi-channel and reset: 4 channels with periods 100/200/300/400 and duty=128 -> mix steps through 0..4 correctly. rst_n pulsed mid-run -> all outputs 0 within the same cycle, restart clean.
